cpu_iprefetch: RTL and testbench



---
 rtl/moxie_pkg.sv | 20 ++
 rtl/cpu_hwfifo.sv | 74 +++++++
 rtl/cpu_iprefetch.sv | 134 +++++++++++++
 tb/tb_cpu_iprefetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/moxie_pkg.sv
// Shared types and constants for the moxie instruction-fetch front end.
package moxie_pkg;

  localparam int HW_W   = 16;
  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] PF_RESET_PC = 32'h0000_1000;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_DISCARD,
    PF_HALT
  } pf_state_e;

  function automatic logic [WORD_W-1:0] word_adr(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_hwfifo.sv
// Circular halfword FIFO: push 0..2, pop 0..3 (clamped), registered 3-entry peek and count.
module cpu_hwfifo
  import moxie_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic [1:0]               push_n_i,
  input  logic [HW_W-1:0]          push_hw0_i,
  input  logic [HW_W-1:0]          push_hw1_i,
  input  logic [1:0]               pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [3*HW_W-1:0]        peek_o,
  output logic [1:0]               avail_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [HW_W-1:0]   mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_nxt, wr_nxt, idx;
  logic [CW-1:0]     cnt_nxt;
  logic [1:0]        pop_eff, avail_nxt;
  logic [3*HW_W-1:0] peek_nxt;
  logic [HW_W-1:0]   hw;

  // Next-state view; peek bypasses the storage so pushed data shows one cycle after the push.
  always_comb begin
    pop_eff = (pop_i > avail_o) ? avail_o : pop_i;
    rd_nxt  = rd_ptr + AW'(pop_eff);
    wr_nxt  = wr_ptr + AW'(push_n_i);
    cnt_nxt = count_o - CW'(pop_eff) + CW'(push_n_i);
    if (clr_i) begin
      rd_nxt  = '0;
      wr_nxt  = '0;
      cnt_nxt = '0;
    end
    peek_nxt = '0;
    idx      = '0;
    hw       = '0;
    for (int i = 0; i < 3; i++) begin
      idx = rd_nxt + AW'(i);
      hw  = mem[idx];
      if (push_n_i != 2'd0 && idx == wr_ptr)          hw = push_hw0_i;
      if (push_n_i == 2'd2 && idx == wr_ptr + AW'(1)) hw = push_hw1_i;
      if (CW'(i) < cnt_nxt) peek_nxt[(2-i)*HW_W +: HW_W] = hw;
    end
    avail_nxt = (cnt_nxt >= CW'(3)) ? 2'd3 : cnt_nxt[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_o <= '0;
      peek_o  <= '0;
      avail_o <= '0;
    end else begin
      rd_ptr  <= rd_nxt;
      wr_ptr  <= wr_nxt;
      count_o <= cnt_nxt;
      peek_o  <= peek_nxt;
      avail_o <= avail_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i && push_n_i != 2'd0) mem[wr_ptr]          <= push_hw0_i;
    if (!clr_i && push_n_i == 2'd2) mem[wr_ptr + AW'(1)] <= push_hw1_i;
  end

endmodule

// File: rtl/cpu_iprefetch.sv
// Instruction prefetch queue: word reads split into big-endian halfwords for cpu_ifetch.
// Optional bus-error handling (mem_err_i, fault_o, HALT state) under `IPREFETCH_BUSERR_EN.
module cpu_iprefetch
  import moxie_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = PF_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] mem_adr_o,
  output logic        mem_stb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_dat_i,
`ifdef IPREFETCH_BUSERR_EN
  input  logic        mem_err_i,
  output logic        fault_o,
  output logic [31:0] fault_adr_o,
`endif
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [47:0] peek_o,
  output logic [1:0]  avail_o,
  input  logic [1:0]  pop_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_e     state;
  logic [29:0]   pc_q;
  logic          skip_q;
  logic [CW-1:0] count;
  logic          ack_fire, bus_err, has_room;
  logic [1:0]    push_n;
  logic [15:0]   push_hw0;
  logic          unused_bits;

  assign unused_bits = flush_pc_i[0];

`ifdef IPREFETCH_BUSERR_EN
  assign bus_err = mem_err_i;
`else
  assign bus_err = 1'b0;
`endif

  assign has_room = (count <= CW'(DEPTH - 2));
  assign ack_fire = (state == PF_REQ) && mem_ack_i && !flush_i;
  assign push_n   = ack_fire ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign push_hw0 = skip_q ? mem_dat_i[15:0] : mem_dat_i[31:16];

  cpu_hwfifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush_i),
    .push_n_i   (push_n),
    .push_hw0_i (push_hw0),
    .push_hw1_i (mem_dat_i[15:0]),
    .pop_i      (pop_i),
    .count_o    (count),
    .peek_o     (peek_o),
    .avail_o    (avail_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= PF_IDLE;
      pc_q      <= RESET_PC[31:2];
      skip_q    <= RESET_PC[1];
      mem_stb_o <= 1'b0;
      mem_adr_o <= {RESET_PC[31:2], 2'b00};
`ifdef IPREFETCH_BUSERR_EN
      fault_o     <= 1'b0;
      fault_adr_o <= '0;
`endif
    end else if (flush_i) begin
      pc_q   <= flush_pc_i[31:2];
      skip_q <= flush_pc_i[1];
`ifdef IPREFETCH_BUSERR_EN
      fault_o     <= 1'b0;
      fault_adr_o <= '0;
`endif
      // An open bus cycle cannot be abandoned; its response is dropped in DISCARD.
      if ((state == PF_REQ || state == PF_DISCARD) && !(mem_ack_i || bus_err)) begin
        state <= PF_DISCARD;
      end else begin
        state     <= PF_IDLE;
        mem_stb_o <= 1'b0;
      end
    end else begin
      case (state)
        PF_IDLE: begin
          if (has_room) begin
            state     <= PF_REQ;
            mem_stb_o <= 1'b1;
            mem_adr_o <= {pc_q, 2'b00};
          end
        end
        PF_REQ: begin
          if (mem_ack_i) begin
            state     <= PF_IDLE;
            mem_stb_o <= 1'b0;
            pc_q      <= pc_q + 30'd1;
            skip_q    <= 1'b0;
          end else if (bus_err) begin
            state     <= PF_HALT;
            mem_stb_o <= 1'b0;
`ifdef IPREFETCH_BUSERR_EN
            fault_o     <= 1'b1;
            fault_adr_o <= mem_adr_o;
`endif
          end
        end
        PF_DISCARD: begin
          // An error here only ends the stale cycle; it never raises a fault.
          if (mem_ack_i || bus_err) begin
            state     <= PF_IDLE;
            mem_stb_o <= 1'b0;
          end
        end
        default: begin
          mem_stb_o <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && pop_i > avail_o)
      $display("cpu_iprefetch: warning, pop_i=%0d exceeds avail_o=%0d, clamped", pop_i, avail_o);
  end
`endif

endmodule

// File: tb/tb_cpu_iprefetch.sv
// Randomized bench for cpu_iprefetch against a halfword-queue reference model.
module tb_cpu_iprefetch;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] mem_adr_o;
  logic        mem_stb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_dat_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic [47:0] peek_o;
  logic [1:0]  avail_o;
  logic [1:0]  pop_i = '0;
`ifdef IPREFETCH_BUSERR_EN
  logic        mem_err_i = 1'b0;
  logic        fault_o;
  logic [31:0] fault_adr_o;
`endif

  cpu_iprefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_1000)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .mem_adr_o  (mem_adr_o),
    .mem_stb_o  (mem_stb_o),
    .mem_ack_i  (mem_ack_i),
    .mem_dat_i  (mem_dat_i),
`ifdef IPREFETCH_BUSERR_EN
    .mem_err_i  (mem_err_i),
    .fault_o    (fault_o),
    .fault_adr_o(fault_adr_o),
`endif
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .peek_o     (peek_o),
    .avail_o    (avail_o),
    .pop_i      (pop_i)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] q[$];
  logic [31:0] exp_pc = 32'h1000;
  bit          skip_m, discard_m, fault_m;
  logic [31:0] fault_adr_m = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA1B2D3D4;
  endfunction

  function automatic int min3(input int s);
    return (s > 3) ? 3 : s;
  endfunction

  function automatic logic [47:0] exp_peek();
    logic [47:0] p = '0;
    if (q.size() > 0) p[47:32] = q[0];
    if (q.size() > 1) p[31:16] = q[1];
    if (q.size() > 2) p[15:0]  = q[2];
    return p;
  endfunction

  // One clock: drive at negedge, update the model at the edge, check #1 later.
  task automatic step(input bit r, input bit ack_req, input bit err_req, input bit fl,
                      input logic [31:0] fpc, input int pop);
    bit          stb_b, ack_b, err_b;
    logic [31:0] adr_b, w;
    int          sz_b, npop;
    @(negedge clk);
    stb_b = mem_stb_o;
    adr_b = mem_adr_o;
    ack_b = ack_req && stb_b;
    err_b = err_req && stb_b && !ack_b;
    w     = mem_word(adr_b);
    rst_i      = r;
    mem_ack_i  = ack_b;
    mem_dat_i  = ack_b ? w : 32'hDEADBEEF;
    flush_i    = fl;
    flush_pc_i = fpc;
    pop_i      = 2'(pop);
`ifdef IPREFETCH_BUSERR_EN
    mem_err_i  = err_b;
`endif
    sz_b = q.size();
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      exp_pc = 32'h1000; skip_m = 0; discard_m = 0; fault_m = 0; fault_adr_m = '0;
    end else if (fl) begin
      q.delete();
      exp_pc    = {fpc[31:2], 2'b00};
      skip_m    = fpc[1];
      discard_m = stb_b && !ack_b && !err_b;
      fault_m = 0; fault_adr_m = '0;
    end else begin
      npop = (pop > min3(sz_b)) ? min3(sz_b) : pop;
      repeat (npop) void'(q.pop_front());
      if (stb_b && (ack_b || err_b)) begin
        if (discard_m) discard_m = 0;
        else if (ack_b) begin
          if (!skip_m) q.push_back(w[31:16]);
          q.push_back(w[15:0]);
          skip_m = 0;
          exp_pc += 4;
        end else begin
          fault_m = 1; fault_adr_m = adr_b;
        end
      end
    end
    check("avail", avail_o, min3(q.size()));
    check("peek", peek_o, exp_peek());
    if (!r && !stb_b && mem_stb_o) begin
      check("issue_adr", mem_adr_o, exp_pc);
      check("issue_space", (sz_b <= DEPTH - 2), 1);
    end
    if (!r && stb_b && !ack_b && !err_b)
      check("stb_hold", {mem_stb_o, mem_adr_o}, {1'b1, adr_b});
    if (!r && stb_b && (ack_b || err_b)) check("gap", mem_stb_o, 0);
    if (fault_m) check("halt_nostb", mem_stb_o, 0);
`ifdef IPREFETCH_BUSERR_EN
    check("fault", fault_o, fault_m);
    check("fault_adr", fault_adr_o, fault_adr_m);
`endif
  endtask

  task automatic wait_stb();
    for (int k = 0; k < 30 && !mem_stb_o; k++) step(0, 0, 0, 0, '0, 0);
    check("stb_seen", mem_stb_o, 1);
  endtask

  initial begin
    logic [31:0] fpc;
    int          p;

    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    check("rst_stb", mem_stb_o, 0);
    check("rst_adr", mem_adr_o, 32'h1000);
    check("rst_avail", avail_o, 0);

    // First fetch after reset.
    wait_stb();
    check("s1_adr", mem_adr_o, 32'h1000);
    step(0, 1, 0, 0, '0, 0);
    check("s1_peek", peek_o[47:16], 32'hA1B2C3D4);
    check("s1_avail", avail_o, 2);

    // Fill with no consumer, then reopen space.
    repeat (40) step(0, 1, 0, 0, '0, 0);
    check("s2_full", avail_o, 3);
    repeat (5) begin
      step(0, 1, 0, 0, '0, 0);
      check("s2_nostb", mem_stb_o, 0);
    end
    step(0, 0, 0, 0, '0, 3);
    wait_stb();
    check("s2_adr", mem_adr_o, 32'h1010);

    // Flush while a request is open: stale response dropped, odd target skips a halfword.
    step(0, 0, 0, 1, 32'h2002, 0);
    step(0, 1, 0, 0, '0, 0);
    check("s3_dropped", avail_o, 0);
    wait_stb();
    check("s3_adr", mem_adr_o, 32'h2000);
    step(0, 1, 0, 0, '0, 0);
    check("s3_avail", avail_o, 1);
    check("s3_h0", peek_o[47:32], 16'hF3D4);

    // Flush coinciding with an ack and a pop.
    wait_stb();
    step(0, 1, 0, 1, 32'h3000, 1);
    check("s4_empty", avail_o, 0);
    check("s4_peek", peek_o, 48'h0);
    wait_stb();
    check("s4_adr", mem_adr_o, 32'h3000);

    // Steady stream, consumer takes 3 whenever 3 are available.
    repeat (300) step(0, 1, 0, 0, '0, (min3(q.size()) == 3) ? 3 : 0);

    // Random traffic with occasional flushes.
    repeat (2000) begin
      fpc = $urandom;
      fpc[31:16] = '0;
      fpc[0] = 1'b0;
      p = $urandom_range(0, min3(q.size()));
      step(0, ($urandom % 3) != 0, 0, ($urandom % 40) == 0, fpc, p);
    end

    // Over-large pop is clamped to what is available.
    step(0, 0, 0, 1, 32'h4002, 0);
    wait_stb();
    step(0, 1, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 3);
    check("clamp", avail_o, 0);

    // Reset wins over a coincident ack.
    wait_stb();
    step(1, 1, 0, 0, '0, 0);
    check("rst_ack_avail", avail_o, 0);
    check("rst_ack_stb", mem_stb_o, 0);
    check("rst_ack_adr", mem_adr_o, 32'h1000);

`ifdef IPREFETCH_BUSERR_EN
    step(0, 0, 0, 0, '0, 0);
    wait_stb();
    step(0, 1, 0, 0, '0, 0);
    wait_stb();
    step(0, 1, 0, 0, '0, 0);
    wait_stb();
    check("err_adr", mem_adr_o, 32'h1008);
    step(0, 0, 1, 0, '0, 0);
    check("err_fault", fault_o, 1);
    check("err_fault_adr", fault_adr_o, 32'h1008);
    repeat (10) step(0, 1, 0, 0, '0, min3(q.size()));
    check("err_drained", avail_o, 0);
    step(0, 0, 0, 1, 32'h5000, 0);
    check("err_cleared", fault_o, 0);
    wait_stb();
    check("err_resume", mem_adr_o, 32'h5000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
